d_clock_param: RTL and testbench

D_CLOCK_PARAM -- requirements
Module: d_clock_param

---
 rtl/d_clock_param.sv | 126 ++++++++++++
 tb/tb_d_clock_param.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/d_clock_param.sv
// Prescaled BCD time-of-day clock with a guarded time load, an alarm compare and a midnight pulse.
// Time is always held as 24-hour BCD; 12-hour display is derived combinationally.
module d_clock_param #(
  parameter int CLK_DIV = 1,
  parameter int DIV_W   = 26
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        mode_12h,
  input  logic        set_valid,
  input  logic [19:0] set_time,
  output logic        set_ready,
  output logic        set_err,
  input  logic        alarm_en,
  input  logic [19:0] alarm_time,
  output logic        alarm_hit,
  output logic        day_tick,
  output logic [3:0]  sec_1,
  output logic [2:0]  sec_2,
  output logic [3:0]  min_1,
  output logic [2:0]  min_2,
  output logic [3:0]  hour_1,
  output logic [1:0]  hour_2,
  output logic        pm,
  output logic [20:0] register
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [19:0]      t, t_nxt;
  logic             set_legal, load_try, load_ok;

  assign tick = (div_cnt == DIV_MAX);

  // Packed fields: {h2[19:18], h1[17:14], m2[13:11], m1[10:7], s2[6:4], s1[3:0]}
  always_comb begin
    set_legal = (set_time[3:0] <= 4'd9) && (set_time[6:4] <= 3'd5) &&
                (set_time[10:7] <= 4'd9) && (set_time[13:11] <= 3'd5) &&
                (((set_time[19:18] < 2'd2) && (set_time[17:14] <= 4'd9)) ||
                 ((set_time[19:18] == 2'd2) && (set_time[17:14] <= 4'd3)));
  end

  assign load_try = set_valid && set_ready;
  assign load_ok  = load_try && set_legal;

  // Ripple-carry through the BCD digits; 23:59:59 wraps to all zeros.
  always_comb begin
    t_nxt = t;
    if (t[3:0] != 4'd9) t_nxt[3:0] = t[3:0] + 4'd1;
    else begin
      t_nxt[3:0] = 4'd0;
      if (t[6:4] != 3'd5) t_nxt[6:4] = t[6:4] + 3'd1;
      else begin
        t_nxt[6:4] = 3'd0;
        if (t[10:7] != 4'd9) t_nxt[10:7] = t[10:7] + 4'd1;
        else begin
          t_nxt[10:7] = 4'd0;
          if (t[13:11] != 3'd5) t_nxt[13:11] = t[13:11] + 3'd1;
          else begin
            t_nxt[13:11] = 3'd0;
            if ((t[19:18] == 2'd2) && (t[17:14] == 4'd3)) t_nxt[19:14] = 6'd0;
            else if (t[17:14] == 4'd9) begin
              t_nxt[17:14] = 4'd0;
              t_nxt[19:18] = t[19:18] + 2'd1;
            end else t_nxt[17:14] = t[17:14] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      t         <= '0;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      alarm_hit <= 1'b0;
      day_tick  <= 1'b0;
    end else begin
      set_ready <= !load_try;
      set_err   <= load_try && !set_legal;
      alarm_hit <= 1'b0;
      day_tick  <= 1'b0;
      // A load swallows a coincident tick and restarts the second.
      if (load_ok) begin
        t       <= set_time;
        div_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) begin
          t         <= t_nxt;
          alarm_hit <= alarm_en && (t_nxt == alarm_time);
          day_tick  <= (t_nxt == 20'd0);
        end
      end
    end
  end

  logic [4:0] h_bin, h_12;

  always_comb begin
    h_bin = 5'(t[19:18]) * 5'd10 + 5'(t[17:14]);
    if (h_bin == 5'd0)      h_12 = 5'd12;
    else if (h_bin > 5'd12) h_12 = h_bin - 5'd12;
    else                    h_12 = h_bin;
    if (mode_12h) begin
      hour_2 = (h_12 >= 5'd10) ? 2'd1 : 2'd0;
      hour_1 = (h_12 >= 5'd10) ? 4'(h_12 - 5'd10) : 4'(h_12);
      pm     = (h_bin >= 5'd12);
    end else begin
      hour_2 = t[19:18];
      hour_1 = t[17:14];
      pm     = 1'b0;
    end
  end

  assign sec_1    = t[3:0];
  assign sec_2    = t[6:4];
  assign min_1    = t[10:7];
  assign min_2    = t[13:11];
  assign register = {pm, hour_2, hour_1, min_2, min_1, sec_2, sec_1};

endmodule

// File: tb/tb_d_clock_param.sv
// Directed bench for d_clock_param at CLK_DIV=4: counting, load/reject, 12h display, alarm, rollover.
module tb_d_clock_param;
  logic        clk_1 = 1'b0;
  logic        rst, mode_12h, set_valid, alarm_en;
  logic [19:0] set_time, alarm_time;
  logic        set_ready, set_err, alarm_hit, day_tick, pm;
  logic [3:0]  sec_1, min_1, hour_1;
  logic [2:0]  sec_2, min_2;
  logic [1:0]  hour_2;
  logic [20:0] register;

  int checks = 0;
  int failures = 0;
  int hits, days;

  d_clock_param #(.CLK_DIV(4), .DIV_W(26)) dut (
    .clk_1(clk_1), .rst(rst), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_time(set_time), .set_ready(set_ready), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_hit(alarm_hit), .day_tick(day_tick),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2), .pm(pm), .register(register)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode_12h = 1'b0; set_valid = 1'b0; alarm_en = 1'b0;
    set_time = 20'd0; alarm_time = 20'd0;
    step(); step();
    chk("rst_reg24", 32'(register), 32'h0);
    chk("rst_ready", 32'(set_ready), 32'd1);
    chk("rst_pulses", {29'd0, set_err, alarm_hit, day_tick}, 32'd0);
    mode_12h = 1'b1; #1;
    chk("rst_reg12", 32'(register), 32'h048000);   // 12:00:00 pm=0
    mode_12h = 1'b0;

    // Count from reset with alarm at 00:00:05
    alarm_time = 20'h00005; alarm_en = 1'b1;
    rst = 1'b0;
    hits = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      hits += int'(alarm_hit);
      if (i == 3)  chk("pre_first_tick", 32'(sec_1), 32'd0);
      if (i == 4)  chk("first_tick", 32'(sec_1), 32'd1);
      if (i == 20) chk("alarm_at_5", {31'd0, alarm_hit}, 32'd1);
    end
    chk("alarm_count", 32'(hits), 32'd1);
    chk("sec_after_40", {25'd0, sec_2, sec_1}, {25'd0, 3'd1, 4'd0});

    // Alarm disabled, then async reset mid-count
    rst = 1'b1; step(); alarm_en = 1'b0; rst = 1'b0;
    hits = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      hits += int'(alarm_hit);
    end
    chk("alarm_off", 32'(hits), 32'd0);
    chk("sec_after_24", 32'(sec_1), 32'd6);
    #2 rst = 1'b1; #1;
    chk("async_rst", 32'(register), 32'h0);
    chk("async_rst_ready", 32'(set_ready), 32'd1);

    // Load 23:59:58 mid-count, roll through midnight
    step(); rst = 1'b0;
    step(); step();
    set_time = 20'h8ECD8; set_valid = 1'b1;
    step(); set_valid = 1'b0;
    chk("load_2359", 32'(register), 32'h08ECD8);
    chk("ready_low", 32'(set_ready), 32'd0);
    days = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      days += int'(day_tick);
      if (i == 1) chk("ready_back", 32'(set_ready), 32'd1);
      if (i == 3) chk("presc_cleared", 32'(register), 32'h08ECD8);
      if (i == 4) chk("to_235959", 32'(register), 32'h08ECD9);
      if (i == 8) chk("day_tick", {31'd0, day_tick}, 32'd1);
    end
    chk("day_count", 32'(days), 32'd1);
    chk("midnight24", 32'(register), 32'h0);
    mode_12h = 1'b1; #1;
    chk("midnight12", 32'(register), 32'h048000);
    mode_12h = 1'b0;

    // Load 13:05:00 and toggle to 12h in the same cycle
    set_time = 20'h4C280; set_valid = 1'b1;
    step(); set_valid = 1'b0;
    chk("load_1305", 32'(register), 32'h04C280);
    mode_12h = 1'b1; #1;
    chk("pm_1305", {28'd0, pm, hour_2, hour_1[0]}, {28'd0, 1'b1, 2'd0, 1'b1});
    chk("hour1_1305", 32'(hour_1), 32'd1);
    chk("reg12_1305", 32'(register), 32'h104280);
    mode_12h = 1'b0;

    // Reject s2=6: time held, prescaler keeps running
    step();
    set_time = 20'h4C260; set_valid = 1'b1;
    step(); set_valid = 1'b0;
    chk("err_s2", {30'd0, set_err, set_ready}, {30'd0, 1'b1, 1'b0});
    chk("held_s2", 32'(register), 32'h04C280);
    step();
    chk("err_clear", {30'd0, set_err, set_ready}, {30'd0, 1'b0, 1'b1});
    step();
    chk("tick_after_rej", 32'(register), 32'h04C281);
    set_time = 20'h90000; set_valid = 1'b1;   // 24:00:00
    step(); set_valid = 1'b0;
    chk("err_24h", {31'd0, set_err}, 32'd1);
    chk("held_24h", 32'(register), 32'h04C281);

    // Load coinciding with a tick; alarm matches the loaded value but must stay quiet
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    alarm_time = 20'h41030; alarm_en = 1'b1;
    set_time = 20'h41030; set_valid = 1'b1;
    step();
    chk("load_wins", 32'(register), 32'h041030);
    chk("no_alarm_on_load", {31'd0, alarm_hit}, 32'd0);
    chk("hold_ready0", 32'(set_ready), 32'd0);
    step();
    chk("hold_ready1", 32'(set_ready), 32'd1);
    step();
    chk("hold_ready2", 32'(set_ready), 32'd0);
    set_valid = 1'b0; alarm_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
